// File: rtl/freqdiv_pkg.sv
// Shared definitions for the frequency divider / clock ratio detector family:
// measurement FSM state encoding, default counter width and small helpers.
package freqdiv_pkg;

    // Default width of the period / high-time counters.
    localparam int DEF_CNT_W = 8;

    // Measurement FSM states. Encoding is fixed so that benches of the
    // frequency divider can decode the state when probing it.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2
    } fsm_state_e;

    // Bits needed to hold a match count in 0 .. lock_count-1.
    // Never returns less than 1, so a LOCK_COUNT of 1 still yields a legal vector.
    function automatic int unsigned match_width(input int unsigned lock_count);
        int unsigned w;
        w = 32'd1;
        while ((32'd1 << w) < lock_count) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

    // Saturating increment of a match count against a top value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] top);
        logic [31:0] res;
        if (value >= top) begin
            res = top;
        end else begin
            res = value + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous divided clock into the clk domain through a
// multi-flop synchronizer and flags the rising edges of the synced copy.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;

    // Synchronizer chain plus the one-cycle delayed copy used for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign o_s    = w_s;
    assign o_rise = w_s & ~r_s_d;

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures a divided clock against the master clock: recovers the division
// ratio (rising-to-rising interval) and the high time, both in clk cycles,
// and reports lock once the same period has been seen repeatedly.
module clock_ratio_detector
    import freqdiv_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_div_clk_in,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_time,
    output logic             o_period_valid,
    output logic             o_locked,
    output logic             o_overflow
);

    localparam int unsigned     MATCH_W   = match_width(LOCK_COUNT);
    localparam logic [31:0]     TOP_32    = 32'(LOCK_COUNT - 1);
    localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // Synchronized input and its rising-edge strobe.
    logic w_s;
    logic w_rise;

    // FSM state and measurement counters.
    fsm_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hcnt;

    // Output and lock bookkeeping registers.
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_high_time;
    logic               r_period_valid;
    logic               r_locked;
    logic               r_overflow;
    logic [MATCH_W-1:0] r_match;
    // Set once a period has been captured since the last (re)acquisition, so the
    // first interval of a fresh measurement is never compared with a stale one.
    logic               r_have_prev;

    // Next-value helpers for the capture path.
    logic [CNT_W-1:0]   w_s_ext;
    logic               w_period_eq;
    logic [MATCH_W-1:0] w_match_next;
    logic               w_locked_next;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_div_clk_in),
        .o_s     (w_s),
        .o_rise  (w_rise)
    );

    assign w_s_ext = {{(CNT_W-1){1'b0}}, w_s};

    // Lock evaluation for the interval that closes on the current rise.
    always_comb begin
        w_period_eq   = 1'b0;
        w_match_next  = {MATCH_W{1'b0}};
        w_locked_next = 1'b0;
        if (r_have_prev && (r_cnt == r_period)) begin
            w_period_eq   = 1'b1;
            w_match_next  = MATCH_W'(sat_inc(32'(r_match), TOP_32));
            w_locked_next = r_locked | (w_match_next == MATCH_TOP);
        end else begin
            w_period_eq   = 1'b0;
            w_match_next  = {MATCH_W{1'b0}};
            w_locked_next = 1'b0;
        end
    end

    // Measurement FSM: counters, captures, lock tracking and overflow detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= CNT_ZERO;
            r_hcnt         <= CNT_ZERO;
            r_period       <= CNT_ZERO;
            r_high_time    <= CNT_ZERO;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_overflow     <= 1'b0;
            r_match        <= {MATCH_W{1'b0}};
            r_have_prev    <= 1'b0;
        end else if (!i_enable) begin
            // Disabling drops any interval in flight; period/high_time keep their value.
            r_state        <= IDLE;
            r_cnt          <= CNT_ZERO;
            r_hcnt         <= CNT_ZERO;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_overflow     <= 1'b0;
            r_match        <= {MATCH_W{1'b0}};
            r_have_prev    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt          <= CNT_ZERO;
                    r_hcnt         <= CNT_ZERO;
                    r_period_valid <= 1'b0;
                    r_state        <= ACQUIRE;
                end

                ACQUIRE: begin
                    // The interval before the first rise is partial and is discarded.
                    r_period_valid <= 1'b0;
                    if (w_rise) begin
                        r_cnt   <= CNT_ONE;
                        r_hcnt  <= w_s_ext;
                        r_state <= MEASURE;
                    end else begin
                        r_cnt   <= CNT_ZERO;
                        r_hcnt  <= CNT_ZERO;
                        r_state <= ACQUIRE;
                    end
                end

                MEASURE: begin
                    if (w_rise) begin
                        // A rise wins over counter saturation in the same cycle.
                        r_period       <= r_cnt;
                        r_high_time    <= r_hcnt;
                        r_period_valid <= 1'b1;
                        r_match        <= w_match_next;
                        r_locked       <= w_locked_next;
                        r_have_prev    <= 1'b1;
                        r_cnt          <= CNT_ONE;
                        r_hcnt         <= w_s_ext;
                        r_state        <= MEASURE;
                    end else if (r_cnt == CNT_MAX) begin
                        // Interval too long to represent: flag it and start over.
                        r_period_valid <= 1'b0;
                        r_overflow     <= 1'b1;
                        r_locked       <= 1'b0;
                        r_match        <= {MATCH_W{1'b0}};
                        r_have_prev    <= 1'b0;
                        r_cnt          <= CNT_ZERO;
                        r_hcnt         <= CNT_ZERO;
                        r_state        <= ACQUIRE;
                    end else begin
                        // hcnt never exceeds cnt, so it cannot wrap on its own.
                        r_period_valid <= 1'b0;
                        r_cnt          <= r_cnt + CNT_ONE;
                        r_hcnt         <= r_hcnt + w_s_ext;
                        r_state        <= MEASURE;
                    end
                end

                default: begin
                    r_period_valid <= 1'b0;
                    r_cnt          <= CNT_ZERO;
                    r_hcnt         <= CNT_ZERO;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

    assign o_period       = r_period;
    assign o_high_time    = r_high_time;
    assign o_period_valid = r_period_valid;
    assign o_locked       = r_locked;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_clock_ratio_detector.sv
// Scoreboard bench for clock_ratio_detector: directed divided-clock waveforms
// with hand-computed expected captures, checked by an independent monitor.
module tb_clock_ratio_detector;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             div_clk;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             overflow;

    typedef struct packed {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
        logic             l;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulse  = 0;

    always #5 clk = ~clk;

    clock_ratio_detector #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .LOCK_COUNT  (4)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_div_clk_in   (div_clk),
        .o_period       (period),
        .o_high_time    (high_time),
        .o_period_valid (period_valid),
        .o_locked       (locked),
        .o_overflow     (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: every valid pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && period_valid === 1'b1) begin
            n_checks++;
            n_pulse++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: got period=%0d high=%0d locked=%0d ovf=%0d, expected no pulse",
                         period, high_time, locked, overflow);
            end else begin
                mon_e = exp_q.pop_front();
                if ({period, high_time, locked, overflow} === mon_e) n_pass++;
                else $display("FAIL pulse_%0d: got period=%0d high=%0d locked=%0d ovf=%0d, expected period=%0d high=%0d locked=%0d ovf=%0d",
                              n_pulse, period, high_time, locked, overflow,
                              mon_e.p, mon_e.h, mon_e.l, mon_e.o);
            end
        end
    end

    task automatic push(input int p, input int h, input bit l, input bit o, input int n);
        exp_t e;
        e.p = CNT_W'(p);
        e.h = CNT_W'(h);
        e.l = l;
        e.o = o;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Holds div_clk at a level for n clk cycles, changing it on falling edges.
    task automatic drive(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            div_clk = level;
        end
    endtask

    task automatic gen(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
    endtask

    // Counts clk edges from the one sampling div_clk=1 until period_valid is seen.
    task automatic latency_probe();
        int   k;
        logic seen;
        k    = 0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                k++;
                if (period_valid === 1'b1) seen = 1'b1;
            end
        end
        check("latency_edges", k, 3);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_period"},    period,       0);
        check({tag, "_high_time"}, high_time,    0);
        check({tag, "_valid"},     period_valid, 0);
        check({tag, "_locked"},    locked,       0);
        check({tag, "_overflow"},  overflow,     0);
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        div_clk = 1'b0;
        #10;
        check_zero_outputs("reset");
        #10;
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // Divide by 2: lock on the 4th pulse.
        push(2, 1, 0, 0, 3); push(2, 1, 1, 0, 3);
        gen(2, 1, 7);

        // Divide by 3 (high 2): first pulse still closes a /2 interval.
        push(2, 1, 1, 0, 1); push(3, 2, 0, 0, 3); push(3, 2, 1, 0, 2);
        gen(3, 2, 6);

        // Switch to /5 while locked: unlock on first 5, relock on 4th 5.
        push(3, 2, 1, 0, 1); push(5, 2, 0, 0, 3); push(5, 2, 1, 0, 2);
        gen(5, 2, 6);

        // Input stuck low: overflow, lock lost, no pulse.
        drive(1'b0, 300);
        check("overflow_set", overflow, 1);
        check("overflow_unlock", locked, 0);

        // Input resumes: reacquire, pulses return, overflow stays sticky.
        push(4, 1, 0, 1, 3); push(4, 1, 1, 1, 1);
        gen(4, 1, 5);

        // Longest representable interval: rise coincides with saturation.
        push(4, 1, 1, 1, 1); push(255, 100, 0, 1, 1);
        gen(255, 100, 2);
        push(255, 100, 0, 1, 1); push(5, 2, 0, 1, 2);
        gen(5, 2, 3);

        // Enable dropped for 3 cycles mid-interval.
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("disable_period_hold", period, 5);
        check("disable_overflow_clr", overflow, 0);
        check("disable_locked", locked, 0);
        @(negedge clk);
        enable = 1'b1;
        push(5, 2, 0, 0, 3); push(5, 2, 1, 0, 1);
        gen(5, 2, 5);

        // Reset in the middle of MEASURE.
        push(5, 2, 1, 0, 1); push(3, 1, 0, 0, 2);
        gen(3, 1, 3);
        drive(1'b0, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First rise after reset only starts the measurement.
        gen(4, 2, 1);
        push(4, 2, 0, 0, 1);
        drive(1'b1, 1);
        fork
            latency_probe();
        join_none
        drive(1'b1, 1);
        drive(1'b0, 2);
        push(4, 2, 0, 0, 2);
        gen(4, 2, 2);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("missing_pulses", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
